// File: rtl/serial_pkg.sv
// serial_pkg: register offsets and STATUS/CTRL bit positions shared by the serial FIFO buffer.
package serial_pkg;
  typedef enum logic [2:0] {
    REG_STATUS,
    REG_RX_DATA,
    REG_RX_COUNT,
    REG_TX_DATA,
    REG_TX_COUNT,
    REG_CTRL
  } reg_e;
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_NOT_FULL = 1;
  localparam int ST_RX_OVF = 2;
  localparam int ST_TX_OVF = 3;
  localparam int ST_TX_EMPTY = 4;
  localparam int CT_CLR_RX_OVF = 0;
  localparam int CT_CLR_TX_OVF = 1;
  localparam int CT_FLUSH_RX = 2;
  localparam int CT_FLUSH_TX = 3;
  localparam int CT_IE_RX = 4;
  localparam int CT_IE_TX = 5;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush, occupancy count and combinational head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & !empty;
  // a push into a full FIFO is accepted only when the head leaves on the same edge
  assign do_push = push & (!full | do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push & !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/serial_fifo_buffer.sv
// serial_fifo_buffer: memory-mapped RX/TX character FIFOs bridging a CPU bus to a serial link.
module serial_fifo_buffer
  import serial_pkg::*;
#(
  parameter logic [15:0] MEM_ADDR = 16'hffff,
  parameter int DATA_W = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr_in,
  output logic [31:0]       data_out,
  input  logic              re_in,
  input  logic [31:0]       data_in,
  input  logic              we_in,
  input  logic              s_data_valid_in,
  input  logic [DATA_W-1:0] s_data_in,
  output logic              s_rden_out,
  input  logic              s_data_ready_in,
  output logic [DATA_W-1:0] s_data_out,
  output logic              s_wren_out,
  output logic              irq_out
);
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  logic sel, ctrl_we, flush_rx, flush_tx, rx_pop, tx_wr, tx_pop;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_ovf, tx_ovf, ie_rx, ie_tx;
  logic [2:0] off;
  logic [RCW-1:0] rx_count;
  logic [TCW-1:0] tx_count;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic [31:0] status;
  logic unused;
  assign unused = ^{addr_in[15:5], addr_in[1:0], data_in};
  assign sel = addr_in[31:16] == MEM_ADDR;
  assign off = addr_in[4:2];
  assign ctrl_we = sel & we_in & off == REG_CTRL;
  assign flush_rx = ctrl_we & data_in[CT_FLUSH_RX];
  assign flush_tx = ctrl_we & data_in[CT_FLUSH_TX];
  assign rx_pop = sel & re_in & off == REG_RX_DATA & !rx_empty;
  assign s_rden_out = s_data_valid_in & (!rx_full | rx_pop);
  assign tx_wr = sel & we_in & off == REG_TX_DATA;
  // a flush suppresses the drain so no character escapes from a FIFO being discarded
  assign tx_pop = !tx_empty & s_data_ready_in & !flush_tx;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clock(clock), .reset(reset), .push(s_rden_out), .pop(rx_pop), .flush(flush_rx),
    .din(s_data_in), .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clock(clock), .reset(reset), .push(tx_wr), .pop(tx_pop), .flush(flush_tx),
    .din(data_in[DATA_W-1:0]), .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
  );
  always_comb begin
    status = '0;
    status[ST_RX_NOT_EMPTY] = !rx_empty;
    status[ST_TX_NOT_FULL] = !tx_full;
    status[ST_RX_OVF] = rx_ovf;
    status[ST_TX_OVF] = tx_ovf;
    status[ST_TX_EMPTY] = tx_empty;
  end
  assign data_out = off == REG_STATUS   ? status
                  : off == REG_RX_DATA  ? (rx_empty ? '0 : 32'(rx_head))
                  : off == REG_RX_COUNT ? 32'(rx_count)
                  : off == REG_TX_COUNT ? 32'(tx_count)
                  : off == REG_CTRL     ? {26'd0, ie_tx, ie_rx, 4'd0}
                  : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      s_wren_out <= 1'b0;
      s_data_out <= '0;
      irq_out <= 1'b0;
    end else begin
      rx_ovf <= (s_data_valid_in & rx_full & !rx_pop) | (rx_ovf & !(ctrl_we & data_in[CT_CLR_RX_OVF]));
      tx_ovf <= (tx_wr & tx_full & !tx_pop) | (tx_ovf & !(ctrl_we & data_in[CT_CLR_TX_OVF]));
      if (ctrl_we) {ie_tx, ie_rx} <= {data_in[CT_IE_TX], data_in[CT_IE_RX]};
      s_wren_out <= tx_pop;
      if (tx_pop) s_data_out <= tx_head;
      irq_out <= (ie_rx & !rx_empty) | (ie_tx & tx_empty);
    end
endmodule

// File: doc/serial_fifo_buffer.md
SERIAL_FIFO_BUFFER -- requirements
Module: serial_fifo_buffer

Interface
REQ-001 Parameter MEM_ADDR, default 16'hffff, upper address half-word that selects this block.
REQ-002 Parameter DATA_W, default 8, serial character width; legal range 1..16.
REQ-003 Parameter RX_DEPTH, default 16, RX FIFO entries; power of two, range 2..256.
REQ-004 Parameter TX_DEPTH, default 16, TX FIFO entries; power of two, range 2..256.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 addr_in  in  32  CPU byte address; [31:16] is the block select, [4:2] is the register select.
REQ-008 data_out  out  32  CPU read data, combinational from addr_in.
REQ-009 re_in  in  1  CPU read strobe.
REQ-010 data_in  in  32  CPU write data.
REQ-011 we_in  in  1  CPU write strobe.
REQ-012 s_data_valid_in  in  1  serial RX character available.
REQ-013 s_data_in  in  DATA_W  serial RX character.
REQ-014 s_rden_out  out  1  RX character consumed this cycle.
REQ-015 s_data_ready_in  in  1  serial TX side can accept a character.
REQ-016 s_data_out  out  DATA_W  TX character, registered.
REQ-017 s_wren_out  out  1  TX character valid, one-cycle pulse, registered.
REQ-018 irq_out  out  1  level interrupt, registered.

Function
REQ-019 Register map, selected by addr_in[4:2]: 0 STATUS, 1 RX_DATA, 2 RX_COUNT, 3 TX_DATA, 4 TX_COUNT, 5 CTRL, 6-7 reserved.
REQ-020 data_out SHALL be zero-extended in all cases; reserved offsets read 0; decode SHALL NOT depend on addr_in[31:16].
REQ-021 STATUS layout: bit0 rx_not_empty, bit1 tx_not_full, bit2 rx_overflow (sticky), bit3 tx_overflow (sticky), bit4 tx_empty; all other bits 0.
REQ-022 RX_DATA SHALL read the RX FIFO head, or 0 when the RX FIFO is empty.
REQ-023 An RX pop SHALL occur when the block is selected, re_in=1, offset=1 and the RX FIFO is not empty; a pop on an empty FIFO is ignored.
REQ-024 RX_COUNT and TX_COUNT SHALL read current occupancy, 0..DEPTH, of width clog2(DEPTH)+1.
REQ-025 s_rden_out SHALL equal s_data_valid_in & (rx_not_full | rx_pop), combinationally; s_data_in is written on the same edge.
REQ-026 If s_data_valid_in=1 while the RX FIFO is full and there is no pop, the character is not consumed and rx_overflow is set.
REQ-027 A write with the block selected, we_in=1 and offset=3 SHALL push data_in[DATA_W-1:0] when the TX FIFO is not full; otherwise the data is dropped and tx_overflow is set.
REQ-028 A write to TX_DATA when full in the same cycle as a TX drain pop SHALL be accepted.
REQ-029 TX drain: when the TX FIFO is non-empty and s_data_ready_in=1, pop the head and register it into s_data_out with s_wren_out=1 for one cycle, at a rate of at most one character per cycle.
REQ-030 s_data_out SHALL hold the last sent character between pulses.
REQ-031 CTRL write (offset 5): bit0=1 clears rx_overflow, bit1=1 clears tx_overflow, bit2=1 flushes RX, bit3=1 flushes TX, bit4 is ie_rx, bit5 is ie_tx.
REQ-032 CTRL read SHALL return {26'b0, ie_tx, ie_rx, 4'b0}.
REQ-033 A flush SHALL take priority over a same-cycle push or pop on that FIFO; occupancy is 0 the next cycle.
REQ-034 A same-cycle set and clear of an overflow flag SHALL leave it set.
REQ-035 irq_out SHALL be registered as (ie_rx & rx_not_empty) | (ie_tx & tx_empty), one cycle after the state change.
REQ-036 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or fall below 0.

Reset
REQ-037 Asserting reset (low) SHALL immediately clear FIFO pointers and counts, overflow flags, ie_rx and ie_tx, s_wren_out, s_data_out and irq_out to 0, independent of clock.
REQ-038 The first push or pop SHALL occur no earlier than the first rising edge after reset deasserts; a reset mid-transfer discards all FIFO content.

Structure
REQ-039 A shared package/include serial_pkg SHALL hold the register offset constants and the STATUS/CTRL bit positions.
REQ-040 One sub-module, sync_fifo (parameters WIDTH and DEPTH; push, pop, flush, full, empty, count, head), SHALL be instantiated twice, once for RX and once for TX.

Verification
REQ-041 RX path: present 0x41, 0x42 with valid; then 2 CPU reads at 0xffff0004 -> data_out 0x41 then 0x42, RX_COUNT 2->1->0, STATUS.bit0 goes 1->0.
REQ-042 RX full (DEPTH=4): hold valid with 5 characters and no reads -> 4 accepted, s_rden_out=0 on the 5th, rx_overflow=1; CTRL write 0x1 -> flag cleared.
REQ-043 TX: s_data_ready_in=0, write 0x55, 0x66 to 0xffff000c -> no s_wren_out; raise ready -> pulses on consecutive cycles with s_data_out 0x55 then 0x66, tx_empty=1.
REQ-044 TX overflow: DEPTH=4, ready=0, 5 writes -> TX_COUNT 4, tx_overflow=1; CTRL write 0x8 -> TX_COUNT 0 next cycle.
REQ-045 Interrupt and reset: ie_rx=1 and one RX character -> irq_out=1 one cycle later; assert reset mid-cycle -> irq_out, counts and s_wren_out go to 0 before the next edge.
